// File: rtl/bist_controller_param.sv
// Scan-BIST controller: Galois LFSR pattern source, shift/capture sequencer,
// multi-input MISR compactor and golden-signature compare with learn mode.
module bist_controller_param #(
  parameter int                N_CHAINS   = 4,
  parameter int                CHAIN_LEN  = 57,
  parameter int                N_PATTERNS = 2000,
  parameter int                LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] LFSR_POLY  = 16'h0039,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 16'hACE1,
  parameter int                MISR_W     = 16,
  parameter logic [MISR_W-1:0] MISR_POLY  = 16'h0039,
  parameter logic [MISR_W-1:0] GOLDEN_SIG = 16'h0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bistmode,
  input  logic                learn,
  output logic                bistdone,
  output logic                bistpass,
  output logic                cut_scanmode,
  output logic [N_CHAINS-1:0] cut_sdi,
  input  logic [N_CHAINS-1:0] cut_sdo,
  output logic [MISR_W-1:0]   signature
);

  localparam int BIT_W = $clog2(CHAIN_LEN + 1);
  localparam int PAT_W = $clog2(N_PATTERNS + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CHAIN_LEN - 1);
  localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(N_PATTERNS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    CAPTURE = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_nxt;
  logic [MISR_W-1:0] misr;
  logic [MISR_W-1:0] misr_nxt;
  logic [MISR_W-1:0] sdo_ext;
  logic [MISR_W-1:0] golden;
  logic [BIT_W-1:0]  bit_cnt;
  logic [PAT_W-1:0]  pat_cnt;
  logic              bit_last;
  logic              pat_last;
  logic              abort;

  assign bit_last = (bit_cnt == BIT_LAST);
  assign pat_last = (pat_cnt == PAT_LAST);
  assign abort    = (state != IDLE) && !bistmode;

  always_comb begin
    sdo_ext = '0;
    sdo_ext[N_CHAINS-1:0] = cut_sdo;
    lfsr_nxt = {lfsr[LFSR_W-2:0], 1'b0} ^ (lfsr[LFSR_W-1] ? LFSR_POLY : '0);
    misr_nxt = {misr[MISR_W-2:0], 1'b0} ^ (misr[MISR_W-1] ? MISR_POLY : '0) ^ sdo_ext;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Dropping bistmode anywhere outside IDLE abandons the run; there is no resume.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bistmode) state_nxt = SHIFT;
      SHIFT: begin
        if (!bistmode) begin
          state_nxt = IDLE;
        end else if (bit_last) begin
          state_nxt = pat_last ? COMPARE : CAPTURE;
        end
      end
      CAPTURE: state_nxt = bistmode ? SHIFT : IDLE;
      COMPARE: state_nxt = bistmode ? DONE : IDLE;
      DONE:    if (!bistmode) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The first shift group only loads the chains, so the MISR waits for pat_cnt != 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr     <= LFSR_SEED;
      misr     <= '0;
      golden   <= GOLDEN_SIG;
      bit_cnt  <= '0;
      pat_cnt  <= '0;
      bistpass <= 1'b0;
    end else if (abort) begin
      bistpass <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bistmode) begin
            lfsr     <= LFSR_SEED;
            misr     <= '0;
            bit_cnt  <= '0;
            pat_cnt  <= '0;
            bistpass <= 1'b0;
          end
        end
        SHIFT: begin
          lfsr <= lfsr_nxt;
          if (pat_cnt != '0) begin
            misr <= misr_nxt;
          end
          bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
        end
        CAPTURE: begin
          pat_cnt <= pat_cnt + 1'b1;
        end
        COMPARE: begin
          if (learn) begin
            golden   <= misr;
            bistpass <= 1'b1;
          end else begin
            bistpass <= (misr == golden);
          end
        end
        default: begin
        end
      endcase
    end
  end

  for (genvar c = 0; c < N_CHAINS; c++) begin : g_sdi
    assign cut_sdi[c] = lfsr[(c * LFSR_W) / N_CHAINS];
  end

  assign cut_scanmode = (state == SHIFT);
  assign bistdone     = (state == DONE);
  assign signature    = misr;

endmodule

// File: tb/tb_bist_controller_param.sv
// Bench for bist_controller_param: a hand-derived cycle table on a tiny 4-bit
// instance, plus full runs of a small 16-bit instance against a behavioural CUT.
module tb_bist_controller_param;

  localparam int N_CH    = 4;
  localparam int CL_A    = 5;
  localparam int NP_A    = 6;
  localparam int TOTAL   = CL_A * (NP_A + 1);
  localparam int LAT_A   = CL_A * (NP_A + 1) + NP_A + 1;
  localparam int RUN_LIM = LAT_A + 20;

  logic            clk;
  logic            rst;
  logic            bistmode;
  logic            learn;
  logic            bistdone;
  logic            bistpass;
  logic            cut_scanmode;
  logic [N_CH-1:0] cut_sdi;
  logic [N_CH-1:0] cut_sdo;
  logic [15:0]     signature;

  logic            bistmode_b;
  logic            learn_b;
  logic            bistdone_b;
  logic            bistpass_b;
  logic            cut_scanmode_b;
  logic [3:0]      cut_sdi_b;
  logic [3:0]      cut_sdo_b;
  logic [15:0]     signature_b;

  int n_cmp;
  int n_err;

  logic [CL_A-1:0] key   [N_CH];
  logic [CL_A-1:0] chain [N_CH];
  logic [N_CH-1:0] fault_mask;
  logic [N_CH-1:0] sdi_exp [TOTAL];
  logic [15:0]     golden_m;

  typedef struct {
    logic       bistmode;
    logic       exp_scan;
    logic       exp_done;
    logic       exp_pass;
    logic [3:0] exp_sdi;
  } vec_t;

  vec_t vecs [15];

  bist_controller_param #(
    .N_CHAINS(N_CH), .CHAIN_LEN(CL_A), .N_PATTERNS(NP_A)
  ) dut (
    .clk(clk), .rst(rst), .bistmode(bistmode), .learn(learn),
    .bistdone(bistdone), .bistpass(bistpass), .cut_scanmode(cut_scanmode),
    .cut_sdi(cut_sdi), .cut_sdo(cut_sdo), .signature(signature)
  );

  bist_controller_param #(
    .N_CHAINS(4), .CHAIN_LEN(3), .N_PATTERNS(2),
    .LFSR_W(4), .LFSR_POLY(4'h3), .LFSR_SEED(4'h1)
  ) dut_b (
    .clk(clk), .rst(rst), .bistmode(bistmode_b), .learn(learn_b),
    .bistdone(bistdone_b), .bistpass(bistpass_b), .cut_scanmode(cut_scanmode_b),
    .cut_sdi(cut_sdi_b), .cut_sdo(cut_sdo_b), .signature(signature_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign cut_sdo_b = 4'b0000;

  // Behavioural CUT: chains shift while scanmode is high, otherwise XOR in a per-flop key.
  always @(posedge clk) begin
    for (int c = 0; c < N_CH; c++) begin
      if (cut_scanmode) chain[c] <= {chain[c][CL_A-2:0], cut_sdi[c]};
      else              chain[c] <= chain[c] ^ key[c];
    end
  end

  always_comb begin
    cut_sdo = '0;
    for (int c = 0; c < N_CH; c++) cut_sdo[c] = chain[c][CL_A-1] ^ fault_mask[c];
  end

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return {x[14:0], 1'b0} ^ (x[15] ? 16'h0039 : 16'h0000);
  endfunction

  // Unload step t returns the bit shifted in CL_A steps earlier, flipped by the capture key.
  function automatic logic [15:0] model_sig(input int fault_step);
    logic [15:0]     m;
    logic [N_CH-1:0] sdo;
    int              k;
    m = 16'h0000;
    for (int t = CL_A; t < TOTAL; t++) begin
      k = t % CL_A;
      for (int c = 0; c < N_CH; c++) sdo[c] = sdi_exp[t-CL_A][c] ^ key[c][CL_A-1-k];
      if (t == fault_step) sdo = sdo ^ 4'b0001;
      m = lfsr_step(m) ^ {12'h000, sdo};
    end
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    bistmode_b = v.bistmode;
    @(posedge clk); #1;
    checkOutput($sformatf("b%0d_scan", idx), 32'(cut_scanmode_b), 32'(v.exp_scan));
    checkOutput($sformatf("b%0d_done", idx), 32'(bistdone_b), 32'(v.exp_done));
    checkOutput($sformatf("b%0d_pass", idx), 32'(bistpass_b), 32'(v.exp_pass));
    checkOutput($sformatf("b%0d_sdi", idx), 32'(cut_sdi_b), 32'(v.exp_sdi));
  endtask

  task automatic randomizeKey();
    for (int c = 0; c < N_CH; c++) key[c] = CL_A'($urandom());
  endtask

  task automatic runA(input bit learn_v, input int fault_step, input int abort_step,
                      input logic [15:0] exp_sig, input bit exp_pass, input string tag);
    int sh;
    int lat;
    bit done_seen;
    sh = 0;
    lat = -1;
    done_seen = 1'b0;
    learn = learn_v;
    bistmode = 1'b1;
    @(posedge clk); #1;
    for (int e = 1; e <= RUN_LIM && !done_seen; e++) begin
      fault_mask = 4'b0000;
      if (cut_scanmode) begin
        if (sh < TOTAL) checkOutput({tag, "_sdi"}, 32'(cut_sdi), 32'(sdi_exp[sh]));
        if (sh == fault_step) fault_mask = 4'b0001;
        if (sh == abort_step) bistmode = 1'b0;
        sh++;
      end
      @(posedge clk); #1;
      if (abort_step >= 0 && !bistmode) begin
        fault_mask = 4'b0000;
        checkOutput({tag, "_abort_scan"}, 32'(cut_scanmode), 32'(0));
        checkOutput({tag, "_abort_done"}, 32'(bistdone), 32'(0));
        checkOutput({tag, "_abort_pass"}, 32'(bistpass), 32'(0));
        return;
      end
      if (bistdone) begin
        done_seen = 1'b1;
        lat = e;
      end
    end
    fault_mask = 4'b0000;
    checkOutput({tag, "_latency"}, 32'(lat), 32'(LAT_A));
    checkOutput({tag, "_shifts"}, 32'(sh), 32'(TOTAL));
    checkOutput({tag, "_pass"}, 32'(bistpass), 32'(exp_pass));
    checkOutput({tag, "_sig"}, 32'(signature), 32'(exp_sig));
    @(posedge clk); #1;
    checkOutput({tag, "_done_hold"}, 32'(bistdone), 32'(1));
    checkOutput({tag, "_scan_low"}, 32'(cut_scanmode), 32'(0));
    bistmode = 1'b0;
    @(posedge clk); #1;
    checkOutput({tag, "_exit_done"}, 32'(bistdone), 32'(0));
    checkOutput({tag, "_exit_pass"}, 32'(bistpass), 32'(0));
  endtask

  initial begin
    logic [15:0] l;
    logic [15:0] sig_clean;
    logic [15:0] s;
    bit          lv;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    bistmode = 1'b0;
    learn = 1'b0;
    bistmode_b = 1'b0;
    learn_b = 1'b0;
    fault_mask = 4'b0000;
    golden_m = 16'h0000;

    l = 16'hACE1;
    for (int t = 0; t < TOTAL; t++) begin
      for (int c = 0; c < N_CH; c++) sdi_exp[t][c] = l[4*c];
      l = lfsr_step(l);
    end

    // Hand-derived: scanmode 3 on / 1 off, 4-bit LFSR 1,2,4,8,3,6,C,B,5,A, done after edge 12.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h1};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h2};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h4};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h8};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h8};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h3};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h6};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'hC};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'hC};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'hB};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h5};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'hA};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'hA};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'hA};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'hA};

    #12;
    checkOutput("rst_done", 32'(bistdone), 32'(0));
    checkOutput("rst_pass", 32'(bistpass), 32'(0));
    checkOutput("rst_scan", 32'(cut_scanmode), 32'(0));
    checkOutput("rst_sig", 32'(signature), 32'(0));
    checkOutput("rst_sdi", 32'(cut_sdi), 32'(4'b0001));
    checkOutput("rst_sdi_b", 32'(cut_sdi_b), 32'(4'h1));
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) applyStimulus(vecs[i], i);
    checkOutput("b_sig", 32'(signature_b), 32'(0));

    $display("[TB] learn, compare, fault and abort runs");
    randomizeKey();
    sig_clean = model_sig(-1);
    runA(1'b1, -1, -1, sig_clean, 1'b1, "learn");
    golden_m = sig_clean;
    runA(1'b0, -1, -1, sig_clean, 1'b1, "rerun");
    runA(1'b0, 2*CL_A+1, -1, model_sig(2*CL_A+1), 1'b0, "fault");
    checkOutput("fault_sig_differs", 32'(signature != sig_clean), 32'(1));
    runA(1'b0, -1, 5*CL_A+2, sig_clean, 1'b1, "abort");
    runA(1'b0, -1, -1, sig_clean, 1'b1, "restart");

    $display("[TB] randomized CUT runs");
    for (int it = 0; it < 4; it++) begin
      randomizeKey();
      lv = 1'($urandom_range(0, 1));
      s = model_sig(-1);
      runA(lv, -1, -1, s, lv ? 1'b1 : (s == golden_m), $sformatf("rand%0d", it));
      if (lv) golden_m = s;
    end

    $display("[TB] asynchronous reset mid-shift");
    learn = 1'b0;
    bistmode = 1'b1;
    repeat (9) @(posedge clk);
    #2;
    checkOutput("pre_reset_scan", 32'(cut_scanmode), 32'(1));
    rst = 1'b0;
    #1;
    checkOutput("arst_scan", 32'(cut_scanmode), 32'(0));
    checkOutput("arst_done", 32'(bistdone), 32'(0));
    checkOutput("arst_pass", 32'(bistpass), 32'(0));
    checkOutput("arst_sig", 32'(signature), 32'(0));
    checkOutput("arst_sdi", 32'(cut_sdi), 32'(4'b0001));
    bistmode = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    golden_m = 16'h0000;
    s = model_sig(-1);
    runA(1'b0, -1, -1, s, (s == golden_m), "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
